// File: rtl/sr_pkg.sv
// sr_pkg
//   Shared definitions for the SR latch bank.
//   - Conflict-resolution mode constants (MODE parameter values).
//   - 2-bit per-channel state encoding.
//   - Effective request encoding after s/r resolution.
package sr_pkg;

  localparam int SR_SET_DOM = 0;
  localparam int SR_RST_DOM = 1;
  localparam int SR_TOGGLE  = 2;

  localparam int SR_CNT_W = 8;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    HOLD = 2'd1,
    ON   = 2'd2
  } sr_state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_SET  = 2'd1,
    REQ_CLR  = 2'd2
  } sr_req_e;

endpackage

// File: rtl/sr_latch_chan.sv
// sr_latch_chan
//   One SR latch channel with configurable conflict resolution and a
//   minimum-hold interval after a set.
//   Ports:
//     clk       - rising-edge clock
//     reset     - synchronous active-high reset
//     s, r      - set / reset requests, sampled each edge
//     clr_flags - clears the sticky conflict flag
//     q         - registered latch state
//     busy      - channel is inside its minimum-hold interval
//     conflict  - sticky flag, s and r seen together
module sr_latch_chan
  import sr_pkg::*;
#(
  parameter int MODE     = SR_SET_DOM,
  parameter int MIN_HOLD = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  input  logic clr_flags,
  output logic q,
  output logic busy,
  output logic conflict
);

  // Counter load value on entry to HOLD; a hold of N cycles ends on the
  // edge where the counter reads zero, so it starts at N-1.
  localparam logic [SR_CNT_W-1:0] HOLD_INIT =
    (MIN_HOLD == 0) ? '0 : SR_CNT_W'(MIN_HOLD - 1);

  sr_state_e             state_p0;
  logic [SR_CNT_W-1:0]   cnt_p0;
  logic                  pend_p0;
  logic                  q_p0;
  logic                  busy_p0;
  logic                  conflict_p0;
  sr_req_e               req;
  logic                  pend_eff;

  function automatic sr_req_e resolve(input logic s_i, input logic r_i,
                                      input logic q_i);
    sr_req_e res;
    if (s_i && !r_i)       res = REQ_SET;
    else if (r_i && !s_i)  res = REQ_CLR;
    else if (!s_i && !r_i) res = REQ_NONE;
    else if (MODE == SR_SET_DOM) res = REQ_SET;
    else if (MODE == SR_RST_DOM) res = REQ_CLR;
    else                   res = q_i ? REQ_CLR : REQ_SET;
    return res;
  endfunction

  always_comb begin
    req      = resolve(s, r, q_p0);
    // A clear arriving on the final hold edge still counts; a set on that
    // edge withdraws any earlier clear.
    pend_eff = (req == REQ_CLR) || (pend_p0 && (req != REQ_SET));
  end

  // ---- stage p0: state, counter, registered outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0    <= OFF;
      cnt_p0      <= '0;
      pend_p0     <= 1'b0;
      q_p0        <= 1'b0;
      busy_p0     <= 1'b0;
      conflict_p0 <= 1'b0;
    end else begin
      // New conflict on the same edge as clr_flags wins.
      conflict_p0 <= (s && r) || (conflict_p0 && !clr_flags);
      case (state_p0)
        OFF: begin
          if (req == REQ_SET) begin
            q_p0    <= 1'b1;
            pend_p0 <= 1'b0;
            if (MIN_HOLD == 0) begin
              state_p0 <= ON;
              busy_p0  <= 1'b0;
            end else begin
              state_p0 <= HOLD;
              cnt_p0   <= HOLD_INIT;
              busy_p0  <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (cnt_p0 == '0) begin
            pend_p0 <= 1'b0;
            busy_p0 <= 1'b0;
            if (pend_eff) begin
              state_p0 <= OFF;
              q_p0     <= 1'b0;
            end else begin
              state_p0 <= ON;
            end
          end else begin
            cnt_p0 <= cnt_p0 - 1'b1;
            if (req == REQ_CLR)      pend_p0 <= 1'b1;
            else if (req == REQ_SET) pend_p0 <= 1'b0;
          end
        end
        ON: begin
          if (req == REQ_CLR) begin
            state_p0 <= OFF;
            q_p0     <= 1'b0;
          end
        end
        default: begin
          state_p0 <= OFF;
          q_p0     <= 1'b0;
          busy_p0  <= 1'b0;
          pend_p0  <= 1'b0;
        end
      endcase
    end
  end

  assign q        = q_p0;
  assign busy     = busy_p0;
  assign conflict = conflict_p0;

endmodule

// File: rtl/sr_latch_bank.sv
// sr_latch_bank
//   Bank of N independent SR latch channels sharing one clock, reset and
//   conflict-flag clear.
//   Parameters: N (1..32), MODE (0 set-dom, 1 reset-dom, 2 toggle),
//               MIN_HOLD (0..255 cycles q stays high after a set).
//   Ports:
//     clk       - rising-edge clock
//     reset     - synchronous active-high reset
//     s, r      - per-channel set / reset requests
//     clr_flags - clears every conflict flag
//     q         - registered latch state per channel
//     conflict  - sticky per-channel conflict flags
//     busy      - per-channel minimum-hold indicator
module sr_latch_bank
  import sr_pkg::*;
#(
  parameter int N        = 4,
  parameter int MODE     = SR_SET_DOM,
  parameter int MIN_HOLD = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] s,
  input  logic [N-1:0] r,
  input  logic         clr_flags,
  output logic [N-1:0] q,
  output logic [N-1:0] conflict,
  output logic [N-1:0] busy
);

  for (genvar i = 0; i < N; i++) begin : g_chan
    sr_latch_chan #(
      .MODE     (MODE),
      .MIN_HOLD (MIN_HOLD)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .s         (s[i]),
      .r         (r[i]),
      .clr_flags (clr_flags),
      .q         (q[i]),
      .busy      (busy[i]),
      .conflict  (conflict[i])
    );
  end

endmodule

// File: tb/tb_sr_latch_bank.sv
module tb_sr_latch_bank;
  import sr_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] s, r;
  logic       clr_flags;
  int         errors = 0;
  int         checks = 0;

  // dut0: set-dom, no hold; dut1: reset-dom; dut2: toggle; dut3: set-dom, hold 8
  logic [3:0] q0, c0, b0, q1, c1, b1, q2, c2, b2, q3, c3, b3;

  sr_latch_bank #(.N(4), .MODE(SR_SET_DOM), .MIN_HOLD(0)) dut0 (
    .clk(clk), .reset(reset), .s(s), .r(r), .clr_flags(clr_flags),
    .q(q0), .conflict(c0), .busy(b0));
  sr_latch_bank #(.N(4), .MODE(SR_RST_DOM), .MIN_HOLD(0)) dut1 (
    .clk(clk), .reset(reset), .s(s), .r(r), .clr_flags(clr_flags),
    .q(q1), .conflict(c1), .busy(b1));
  sr_latch_bank #(.N(4), .MODE(SR_TOGGLE), .MIN_HOLD(0)) dut2 (
    .clk(clk), .reset(reset), .s(s), .r(r), .clr_flags(clr_flags),
    .q(q2), .conflict(c2), .busy(b2));
  sr_latch_bank #(.N(4), .MODE(SR_SET_DOM), .MIN_HOLD(8)) dut3 (
    .clk(clk), .reset(reset), .s(s), .r(r), .clr_flags(clr_flags),
    .q(q3), .conflict(c3), .busy(b3));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; s = '0; r = '0; clr_flags = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    s = 4'b1111; r = 4'b1111; clr_flags = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; s = '0; r = '0;
    checks++;
    if ({q0, q1, q2, q3} !== 16'h0) begin
      errors++; $display("FAIL reset_q: got %h expected 0000", {q0, q1, q2, q3});
    end
    checks++;
    if ({b0, b1, b2, b3} !== 16'h0) begin
      errors++; $display("FAIL reset_busy: got %h expected 0000", {b0, b1, b2, b3});
    end
    checks++;
    if ({c0, c1, c2, c3} !== 16'h0) begin
      errors++; $display("FAIL reset_conflict: got %h expected 0000", {c0, c1, c2, c3});
    end
  endtask

  task automatic test_set_dom();
    do_reset();
    s = 4'b0001;
    tick();
    s = '0;
    checks++;
    if (q0 !== 4'b0001) begin
      errors++; $display("FAIL set_q_after_set: got %b expected 0001", q0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q0 !== 4'b0001) begin
        errors++; $display("FAIL set_q_held: got %b expected 0001", q0);
      end
    end
    checks++;
    if (b0 !== 4'b0000) begin
      errors++; $display("FAIL set_busy_nohold: got %b expected 0000", b0);
    end
    r = 4'b0001;
    tick();
    r = '0;
    checks++;
    if (q0 !== 4'b0000) begin
      errors++; $display("FAIL set_q_after_clr: got %b expected 0000", q0);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    s = 4'b0010; r = 4'b0010;
    tick();
    s = '0; r = '0;
    checks++;
    if (q1 !== 4'b0000) begin
      errors++; $display("FAIL rstdom_q: got %b expected 0000", q1);
    end
    checks++;
    if (c1 !== 4'b0010) begin
      errors++; $display("FAIL rstdom_conflict: got %b expected 0010", c1);
    end
    checks++;
    if (q0 !== 4'b0010) begin
      errors++; $display("FAIL setdom_conflict_q: got %b expected 0010", q0);
    end
    // clear and a fresh conflict on another channel on the same edge
    clr_flags = 1'b1; s = 4'b1000; r = 4'b1000;
    tick();
    s = '0; r = '0;
    checks++;
    if (c1 !== 4'b1000) begin
      errors++; $display("FAIL clr_vs_new_conflict: got %b expected 1000", c1);
    end
    tick();
    clr_flags = 1'b0;
    checks++;
    if (c1 !== 4'b0000) begin
      errors++; $display("FAIL clr_flags: got %b expected 0000", c1);
    end
  endtask

  task automatic test_toggle();
    logic [3:0] exp_q [3];
    exp_q[0] = 4'b0100; exp_q[1] = 4'b0000; exp_q[2] = 4'b0100;
    do_reset();
    s = 4'b0100; r = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q2 !== exp_q[i]) begin
        errors++; $display("FAIL toggle_q[%0d]: got %b expected %b", i, q2, exp_q[i]);
      end
    end
    s = '0; r = '0;
    checks++;
    if (c2 !== 4'b0100) begin
      errors++; $display("FAIL toggle_conflict: got %b expected 0100", c2);
    end
  endtask

  task automatic test_min_hold();
    int high;
    do_reset();
    high = 0;
    // edge 0: set; edge 2: clear request inside the hold
    for (int e = 0; e < 12; e++) begin
      s = (e == 0) ? 4'b0001 : 4'b0000;
      r = (e == 2) ? 4'b0001 : 4'b0000;
      tick();
      if (q3[0]) high++;
      checks++;
      if (q3[0] !== (e < 8) || b3[0] !== (e < 8)) begin
        errors++;
        $display("FAIL hold_edge%0d: got q=%b busy=%b expected q=%b busy=%b",
                 e, q3[0], b3[0], e < 8, e < 8);
      end
    end
    s = '0; r = '0;
    checks++;
    if (high !== 8) begin
      errors++; $display("FAIL hold_length: got %0d expected 8", high);
    end
  endtask

  task automatic test_hold_cancel();
    do_reset();
    for (int e = 0; e < 11; e++) begin
      s = (e == 0 || e == 4) ? 4'b0001 : 4'b0000;
      r = (e == 2) ? 4'b0001 : 4'b0000;
      tick();
      checks++;
      if (q3[0] !== 1'b1 || b3[0] !== (e < 8)) begin
        errors++;
        $display("FAIL cancel_edge%0d: got q=%b busy=%b expected q=1 busy=%b",
                 e, q3[0], b3[0], e < 8);
      end
    end
    // channel is ON now: a clear acts on the next edge
    s = '0; r = 4'b0001;
    tick();
    r = '0;
    checks++;
    if (q3 !== 4'b0000) begin
      errors++; $display("FAIL on_clr: got %b expected 0000", q3);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    s = 4'b0001; tick();
    r = 4'b0001; tick();   // conflict on edge 1, set-dominant
    s = '0;      tick();   // pending clear on edge 2
    r = '0;
    checks++;
    if (c3 !== 4'b0001 || b3 !== 4'b0001) begin
      errors++; $display("FAIL pre_reset: got c=%b b=%b expected c=0001 b=0001", c3, b3);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (q3 !== 4'b0000 || b3 !== 4'b0000 || c3 !== 4'b0000) begin
      errors++;
      $display("FAIL mid_hold_reset: got q=%b b=%b c=%b expected 0000", q3, b3, c3);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (q3 !== 4'b0000 || b3 !== 4'b0000) begin
        errors++; $display("FAIL post_reset_idle%0d: got q=%b b=%b expected 0000", i, q3, b3);
      end
    end
  endtask

  task automatic test_back_to_back();
    // channels run independently: ch1 held 8, ch3 cleared via hold path
    do_reset();
    s = 4'b1010; tick();
    s = 4'b0000; r = 4'b1000; tick();
    r = '0;
    for (int i = 0; i < 7; i++) tick();   // edge 8 reached
    checks++;
    if (q3 !== 4'b0010 || b3 !== 4'b0000) begin
      errors++; $display("FAIL b2b_channels: got q=%b b=%b expected q=0010 b=0000", q3, b3);
    end
  endtask

  initial begin
    reset = 1'b1; s = '0; r = '0; clr_flags = 1'b0;
    test_reset();
    test_set_dom();
    test_conflict();
    test_toggle();
    test_min_hold();
    test_hold_cancel();
    test_reset_mid_hold();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sr_latch_bank.md
SR_LATCH_BANK -- requirements
Module: sr_latch_bank

Interface
REQ-001 Parameter N, default 4: number of independent SR channels, 1..32.
REQ-002 Parameter MODE, default 0: conflict resolution, 0 set-dominant, 1 reset-dominant, 2 toggle.
REQ-003 Parameter MIN_HOLD, default 8: minimum cycles q stays 1 after a set; 0 disables, max 255.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 s  input  N  per-channel set request, sampled each rising edge.
REQ-007 r  input  N  per-channel reset request, sampled each rising edge.
REQ-008 clr_flags  input  1  clears all conflict flags.
REQ-009 q  output  N  registered latch state per channel.
REQ-010 conflict  output  N  sticky flag: s and r seen high together on that channel.
REQ-011 busy  output  N  channel is in minimum-hold interval.

Function
REQ-012 Each channel SHALL be an independent FSM: OFF (q=0), HOLD (q=1, busy=1), ON (q=1, busy=0).
REQ-013 All outputs SHALL be registered; a request sampled at edge k SHALL be visible on q after edge k, one-cycle latency.
REQ-014 Effective request SHALL be: s&~r = SET, r&~s = CLR, neither = NONE; s&r resolves to SET (MODE 0), CLR (MODE 1), or TOGGLE (MODE 2).
REQ-015 TOGGLE SHALL act as SET when q=0 and as CLR when q=1.
REQ-016 OFF: SET SHALL go to HOLD with counter = MIN_HOLD-1 (ON directly if MIN_HOLD=0); CLR/NONE SHALL stay OFF.
REQ-017 HOLD: counter SHALL decrement each cycle; CLR SHALL set a per-channel pending bit; SET SHALL clear it.
REQ-018 HOLD with counter=0: pending=1 (including CLR this cycle) SHALL go to OFF; otherwise SHALL go to ON; pending cleared either way.
REQ-019 q SHALL therefore stay 1 for exactly MIN_HOLD cycles when CLR arrives during HOLD.
REQ-020 ON: CLR SHALL go to OFF next edge; SET/NONE SHALL stay ON.
REQ-021 conflict[i] SHALL set on any edge with s[i]&r[i], in every state and mode.
REQ-022 clr_flags SHALL clear all conflict bits; a new conflict on the same edge SHALL win (bit stays 1).
REQ-023 Counter width SHALL be 8 bits; no wrap, it never decrements below 0.

Reset
REQ-024 reset SHALL take precedence over all inputs on the edge it is sampled.
REQ-025 On reset: every channel OFF, q=0, busy=0, conflict=0, pending=0, counter=0.
REQ-026 Reset mid-HOLD SHALL abort the hold; q=0 after that edge with no deferred action.

Structure
REQ-027 Package sr_pkg SHALL hold MODE constants (SR_SET_DOM, SR_RST_DOM, SR_TOGGLE) and the 2-bit state encoding (OFF, HOLD, ON).
REQ-028 Per-channel logic SHALL be sub-module sr_latch_chan; sr_latch_bank SHALL generate N instances plus shared clr_flags fanout.

Verification
REQ-029 MODE0, MIN_HOLD=0, N=4: s=0001 one cycle -> q=0001 next cycle and held; r=0001 -> q=0000 next cycle.
REQ-030 MODE1: s=r=0010 from OFF -> q stays 0000, conflict=0010; clr_flags -> conflict=0000.
REQ-031 MODE2, MIN_HOLD=0: s=r=0100 three consecutive cycles -> q[2] toggles 1,0,1.
REQ-032 MIN_HOLD=8: s[0] at cycle 0, r[0] at cycle 2 -> q[0]=1 for exactly 8 cycles, busy[0]=1 throughout, then q[0]=0.
REQ-033 MIN_HOLD=8: set, r at cycle 2, s at cycle 4 -> q[0] remains 1 after hold, busy drops, state ON.
REQ-034 reset asserted during HOLD with pending CLR -> q=0, busy=0, conflict=0 after that edge; no later transitions without new requests.
